vga_fb_reader: RTL and testbench
================================

Name: vga_fb_reader

Overview:
- Scan-out reader for the 256x256x3-bit video memory that the board-drawing logic fills.
- Generates 640x480@60 timing from the 50 MHz Clock with an internal divide-by-2 pixel tick.
- Drives the memory read address, then presents the returned colour centred on screen. A fixed border colour surrounds the 256x256 window.
- Sits between the video RAM read port and the VGA connector. It is the read-side counterpart of the frame-buffer writer.

Parameters:
- H_VIS, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_VIS, 480, visible lines
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- WIN_X0, 192, first screen column of the frame-buffer window
- WIN_Y0, 112, first screen line of the frame-buffer window
- BORDER_COLOR, 3'd0, colour for visible pixels outside the window

Ports:
- Clock, input, 1, 50 MHz system clock
- Reset2, input, 1, asynchronous active-low reset
- iColor, input, 3, RAM read data; valid 1 Clock after oColorAddress
- oColorAddress, output, 16, RAM read address {row[7:0], col[7:0]}
- oHs, output, 1, horizontal sync, active low
- oVs, output, 1, vertical sync, active low
- oRGB, output, 3, pixel colour {R,G,B}
- oBlank, output, 1, high outside the visible area
- oFrameStart, output, 1, one-Clock pulse when pixel (0,0) is presented

Behaviour:
- One clock (Clock). Reset2 is asynchronous and active-low; all flops clear immediately on assertion.
- Reset values:
  - tick phase 0, hcnt = 0, vcnt = 0
  - oHs = 1, oVs = 1, oRGB = 0, oBlank = 1, oFrameStart = 0, oColorAddress = 0
- Pixel tick:
  - A toggle flop asserts the tick on every 2nd Clock; the first tick is the 2nd Clock after reset release.
  - All counter and output registers update only on tick Clocks.
- Counters:
  - hcnt runs 0..799 (H_VIS+H_FP+H_SYNC+H_BP-1) and wraps to 0.
  - vcnt increments when hcnt wraps, runs 0..524 and wraps to 0.
  - Counter widths are 10 bits; no overflow is possible.
- Window:
  - inwin = (hcnt-WIN_X0) < 256 and (vcnt-WIN_Y0) < 256, both compared as unsigned 10-bit values, so negative offsets fall outside.
  - Address stage: oColorAddress = {vcnt-WIN_Y0, hcnt-WIN_X0}, low 8 bits of each, registered on the tick together with inwin, vis and the sync flags for that position.
  - When not inwin, oColorAddress holds its last value; the RAM read is don't-care.
- Output stage: on the next tick, iColor is valid because the RAM has had 2 Clocks.
  - oRGB = iColor if inwin, else BORDER_COLOR if vis, else 0.
  - oBlank = !vis.
  - oHs = 0 for hcnt in [656,752).
  - oVs = 0 for vcnt in [490,492).
- Latency: every output reflects counter position N at tick N+2, a constant 2-tick pipeline. Sync, blank and colour are mutually aligned.
- oFrameStart: high for exactly one Clock, on the tick at which position (0,0) reaches the outputs.
- Reset mid-line: outputs return to reset values at once; the scan restarts at (0,0) after release. No partial-frame recovery.
- iColor bits above 3 do not exist; no arithmetic on colour.

Decomposition:
- Package vga_pkg:
  - timing constants (H_*/V_* totals, sync start and end)
  - window origin
  - typedef for the 3-bit colour
  - 16-bit frame-buffer address type
- Sub-module vga_timing_gen:
  - tick divider, hcnt/vcnt, vis and sync flags
  - the fb reader instantiates it and adds the address and output pipeline

Test Plan:
- Reset: hold Reset2 = 0 for 5 Clocks -> oHs = 1, oVs = 1, oRGB = 0, oBlank = 1, oColorAddress = 0, oFrameStart = 0.
- Horizontal timing: run 2 lines -> oHs falling-edge period = 1600 Clocks and low width = 192 Clocks. oBlank high for 320 Clocks per line.
- Vertical timing: run 1 full frame:
  - oFrameStart period = 840000 Clocks
  - oVs low width = 3200 Clocks
  - oFrameStart coincides with the first oBlank = 0 of the frame
- Address mapping:
  - At hcnt = 192, vcnt = 112 -> oColorAddress = 0x0000.
  - At hcnt = 447, vcnt = 367 -> oColorAddress = 0xFFFF.
  - At hcnt = 200, vcnt = 113 -> oColorAddress = 0x0108.
- Data alignment: RAM model returns addr[2:0] with 1 Clock latency, BORDER_COLOR = 3'd4:
  - screen pixel (197,112) shows oRGB = 5
  - screen pixel (191,112) shows oRGB = 4
  - screen pixel (700,112) shows oRGB = 0 with oBlank = 1
- Async reset mid-line: drop Reset2 at hcnt = 300 between Clock edges -> outputs at reset values before the next Clock edge. After release, the first oHs low begins 2*(656+2) Clocks later.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared constants and types for the VGA frame-buffer scan-out path.
package vga_pkg;

  // 640x480@60 timing, counted in pixel ticks and lines
  localparam int H_VIS        = 640;
  localparam int H_FP         = 16;
  localparam int H_SYNC       = 96;
  localparam int H_BP         = 48;
  localparam int H_TOTAL      = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int H_SYNC_START = H_VIS + H_FP;
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;

  localparam int V_VIS        = 480;
  localparam int V_FP         = 10;
  localparam int V_SYNC       = 2;
  localparam int V_BP         = 33;
  localparam int V_TOTAL      = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int V_SYNC_START = V_VIS + V_FP;
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;

  // Top-left corner of the 256x256 frame-buffer window on screen
  localparam int WIN_X0   = 192;
  localparam int WIN_Y0   = 112;

  localparam int CNT_W    = 10;

  typedef logic [2:0]       color_t;
  typedef logic [15:0]      fb_addr_t;
  typedef logic [CNT_W-1:0] cnt_t;

  // True when pos lies in [origin, origin+256); a negative offset wraps to a
  // large unsigned value and therefore falls outside.
  function automatic logic in_win(cnt_t pos, cnt_t origin);
    cnt_t d;
    d = pos - origin;
    return (d[CNT_W-1:8] == '0);
  endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// Pixel-tick divider plus horizontal/vertical counters and raw sync/visible flags.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_VIS  = vga_pkg::H_VIS,
  parameter int H_FP   = vga_pkg::H_FP,
  parameter int H_SYNC = vga_pkg::H_SYNC,
  parameter int H_BP   = vga_pkg::H_BP,
  parameter int V_VIS  = vga_pkg::V_VIS,
  parameter int V_FP   = vga_pkg::V_FP,
  parameter int V_SYNC = vga_pkg::V_SYNC,
  parameter int V_BP   = vga_pkg::V_BP
) (
  input  logic i_clk,
  input  logic i_rst_n,
  output logic o_tick,
  output cnt_t o_hcnt,
  output cnt_t o_vcnt,
  output logic o_vis,
  output logic o_hs_n,
  output logic o_vs_n
);

  localparam cnt_t H_LAST  = cnt_t'(H_VIS + H_FP + H_SYNC + H_BP - 1);
  localparam cnt_t V_LAST  = cnt_t'(V_VIS + V_FP + V_SYNC + V_BP - 1);
  localparam cnt_t HS_BEG  = cnt_t'(H_VIS + H_FP);
  localparam cnt_t HS_END  = cnt_t'(H_VIS + H_FP + H_SYNC);
  localparam cnt_t VS_BEG  = cnt_t'(V_VIS + V_FP);
  localparam cnt_t VS_END  = cnt_t'(V_VIS + V_FP + V_SYNC);

  logic r_phase;
  cnt_t r_hcnt;
  cnt_t r_vcnt;

  // Divide-by-2 toggle: the tick is the Clock on which the phase flop is set
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_phase <= 1'b0;
    else          r_phase <= ~r_phase;
  end

  // Raster position, advanced once per pixel tick
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_hcnt <= '0;
      r_vcnt <= '0;
    end else if (r_phase) begin
      if (r_hcnt == H_LAST) begin
        r_hcnt <= '0;
        if (r_vcnt == V_LAST) r_vcnt <= '0;
        else                  r_vcnt <= r_vcnt + cnt_t'(1);
      end else begin
        r_hcnt <= r_hcnt + cnt_t'(1);
      end
    end
  end

  assign o_tick = r_phase;
  assign o_hcnt = r_hcnt;
  assign o_vcnt = r_vcnt;
  assign o_vis  = (r_hcnt < cnt_t'(H_VIS)) && (r_vcnt < cnt_t'(V_VIS));
  assign o_hs_n = !((r_hcnt >= HS_BEG) && (r_hcnt < HS_END));
  assign o_vs_n = !((r_vcnt >= VS_BEG) && (r_vcnt < VS_END));

endmodule

// File: rtl/vga_fb_reader.sv
// Frame-buffer scan-out: issues RAM read addresses for the centred 256x256
// window and presents the returned colour with aligned sync and blank.
module vga_fb_reader
  import vga_pkg::*;
#(
  parameter int     H_VIS        = vga_pkg::H_VIS,
  parameter int     H_FP         = vga_pkg::H_FP,
  parameter int     H_SYNC       = vga_pkg::H_SYNC,
  parameter int     H_BP         = vga_pkg::H_BP,
  parameter int     V_VIS        = vga_pkg::V_VIS,
  parameter int     V_FP         = vga_pkg::V_FP,
  parameter int     V_SYNC       = vga_pkg::V_SYNC,
  parameter int     V_BP         = vga_pkg::V_BP,
  parameter int     WIN_X0       = vga_pkg::WIN_X0,
  parameter int     WIN_Y0       = vga_pkg::WIN_Y0,
  parameter color_t BORDER_COLOR = 3'd0
) (
  input  logic     Clock,
  input  logic     Reset2,
  input  color_t   iColor,
  output fb_addr_t oColorAddress,
  output logic     oHs,
  output logic     oVs,
  output color_t   oRGB,
  output logic     oBlank,
  output logic     oFrameStart
);

  logic w_tick;
  cnt_t w_hcnt;
  cnt_t w_vcnt;
  logic w_vis;
  logic w_hs_n;
  logic w_vs_n;
  logic w_inwin;
  logic [7:0] w_col;
  logic [7:0] w_row;

  vga_timing_gen #(
    .H_VIS (H_VIS),  .H_FP (H_FP),  .H_SYNC (H_SYNC),  .H_BP (H_BP),
    .V_VIS (V_VIS),  .V_FP (V_FP),  .V_SYNC (V_SYNC),  .V_BP (V_BP)
  ) u_timing (
    .i_clk   (Clock),
    .i_rst_n (Reset2),
    .o_tick  (w_tick),
    .o_hcnt  (w_hcnt),
    .o_vcnt  (w_vcnt),
    .o_vis   (w_vis),
    .o_hs_n  (w_hs_n),
    .o_vs_n  (w_vs_n)
  );

  // Visible pixels outside the window get the border; blanking is black
  function automatic color_t pick_color(logic inwin, logic vis, color_t ram, color_t border);
    if (inwin)    return ram;
    else if (vis) return border;
    else          return 3'd0;
  endfunction

  // The low 8 bits of the offset equal the difference of the low 8 bits
  assign w_inwin = in_win(w_hcnt, cnt_t'(WIN_X0)) && in_win(w_vcnt, cnt_t'(WIN_Y0));
  assign w_col   = w_hcnt[7:0] - 8'(WIN_X0);
  assign w_row   = w_vcnt[7:0] - 8'(WIN_Y0);

  fb_addr_t r_addr_p0;
  logic     r_inwin_p0;
  logic     r_vis_p0;
  logic     r_hs_p0;
  logic     r_vs_p0;
  logic     r_fs_p0;

  // ---- stage p0: RAM address and per-position flags ----
  // Address is held outside the window so the RAM port stays quiet
  always_ff @(posedge Clock or negedge Reset2) begin
    if (!Reset2) begin
      r_addr_p0  <= '0;
      r_inwin_p0 <= 1'b0;
      r_vis_p0   <= 1'b0;
      r_hs_p0    <= 1'b1;
      r_vs_p0    <= 1'b1;
      r_fs_p0    <= 1'b0;
    end else if (w_tick) begin
      if (w_inwin) r_addr_p0 <= {w_row, w_col};
      r_inwin_p0 <= w_inwin;
      r_vis_p0   <= w_vis;
      r_hs_p0    <= w_hs_n;
      r_vs_p0    <= w_vs_n;
      r_fs_p0    <= (w_hcnt == '0) && (w_vcnt == '0);
    end
  end

  color_t r_rgb_p1;
  logic   r_blank_p1;
  logic   r_hs_p1;
  logic   r_vs_p1;
  logic   r_fs_p1;

  // ---- stage p1: iColor has had two Clocks since the address; outputs ----
  // Frame-start is cleared on the non-tick Clock so it lasts one Clock only
  always_ff @(posedge Clock or negedge Reset2) begin
    if (!Reset2) begin
      r_rgb_p1   <= '0;
      r_blank_p1 <= 1'b1;
      r_hs_p1    <= 1'b1;
      r_vs_p1    <= 1'b1;
      r_fs_p1    <= 1'b0;
    end else begin
      r_fs_p1 <= w_tick & r_fs_p0;
      if (w_tick) begin
        r_rgb_p1   <= pick_color(r_inwin_p0, r_vis_p0, iColor, BORDER_COLOR);
        r_blank_p1 <= !r_vis_p0;
        r_hs_p1    <= r_hs_p0;
        r_vs_p1    <= r_vs_p0;
      end
    end
  end

  assign oColorAddress = r_addr_p0;
  assign oRGB          = r_rgb_p1;
  assign oBlank        = r_blank_p1;
  assign oHs           = r_hs_p1;
  assign oVs           = r_vs_p1;
  assign oFrameStart   = r_fs_p1;

endmodule

// File: tb/tb_vga_fb_reader.sv
// Bench for vga_fb_reader: instance 0 uses full 640x480 timing, instance 1 a
// short 7-line frame with the window at line 1 so whole frames fit the run.
module tb_vga_fb_reader;

  localparam int HT  = 800;
  localparam int HV  = 640;
  localparam int HSS = 656;
  localparam int HSE = 752;
  localparam int WX  = 192;

  int VT  [2] = '{525, 7};
  int VV  [2] = '{480, 4};
  int VSS [2] = '{490, 5};
  int VSE [2] = '{492, 6};
  int WY  [2] = '{112, 1};

  logic        Clock = 1'b0;
  logic        Reset2 = 1'b0;
  logic [15:0] addr_o  [2];
  logic [2:0]  rgb_o   [2];
  logic [2:0]  icol    [2];
  logic        hs_o    [2];
  logic        vs_o    [2];
  logic        blank_o [2];
  logic        fs_o    [2];

  logic [2:0]  mem [65536];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int e = 0;
  logic [15:0] exp_addr [2];

  always #10 Clock = ~Clock;

  vga_fb_reader #(.BORDER_COLOR(3'd4)) dut_full (
    .Clock(Clock), .Reset2(Reset2), .iColor(icol[0]),
    .oColorAddress(addr_o[0]), .oHs(hs_o[0]), .oVs(vs_o[0]),
    .oRGB(rgb_o[0]), .oBlank(blank_o[0]), .oFrameStart(fs_o[0])
  );

  vga_fb_reader #(.V_VIS(4), .V_FP(1), .V_SYNC(1), .V_BP(1), .WIN_Y0(1),
                  .BORDER_COLOR(3'd4)) dut_small (
    .Clock(Clock), .Reset2(Reset2), .iColor(icol[1]),
    .oColorAddress(addr_o[1]), .oHs(hs_o[1]), .oVs(vs_o[1]),
    .oRGB(rgb_o[1]), .oBlank(blank_o[1]), .oFrameStart(fs_o[1])
  );

  // RAM read port with one Clock of latency
  always @(posedge Clock) begin
    icol[0] <= mem[addr_o[0]];
    icol[1] <= mem[addr_o[1]];
  end

  function automatic int hpos(int p);
    return p % HT;
  endfunction
  function automatic int vpos(int i, int p);
    return (p / HT) % VT[i];
  endfunction
  function automatic bit win_p(int i, int p);
    return (((hpos(p) - WX) & 1023) < 256) && (((vpos(i, p) - WY[i]) & 1023) < 256);
  endfunction
  function automatic logic [15:0] addr_p(int i, int p);
    return 16'((((vpos(i, p) - WY[i]) & 255) * 256) + ((hpos(p) - WX) & 255));
  endfunction

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, expv, $time);
    end
  endtask

  function automatic logic get(int i, int s);
    case (s)
      0: return hs_o[i];
      1: return vs_o[i];
      2: return fs_o[i];
      default: return blank_o[i];
    endcase
  endfunction

  task automatic wait_level(input int i, input int s, input logic lvl,
                            input int budget, input string nm);
    int n;
    n = 0;
    @(negedge Clock);
    while (get(i, s) !== lvl && n < budget) begin
      @(negedge Clock);
      n++;
    end
    if (get(i, s) !== lvl) begin
      checks++;
      errors++;
      $display("FAIL %s timeout after %0d cycles", nm, budget);
    end
  endtask

  // Edges since reset release, and the address the read port must hold:
  // the tick at edge 2(k+1) registers scan position k.
  initial begin
    forever begin
      @(posedge Clock);
      cyc++;
      if (!Reset2) begin
        e = 0;
        exp_addr[0] = 16'h0;
        exp_addr[1] = 16'h0;
      end else begin
        e++;
        if (e % 2 == 0) begin
          if (win_p(0, e/2 - 1)) exp_addr[0] = addr_p(0, e/2 - 1);
          if (win_p(1, e/2 - 1)) exp_addr[1] = addr_p(1, e/2 - 1);
        end
      end
    end
  end

  // Per-cycle comparison: outputs after edge e show scan position e/2-2
  initial begin
    int kt, p, h, v;
    logic [15:0] ea;
    logic [2:0] er;
    logic ehs, evs, eb, ef;
    forever begin
      @(negedge Clock);
      for (int i = 0; i < 2; i++) begin
        kt = e/2 - 1;
        p  = kt - 1;
        ea = 16'h0; er = 3'd0; ehs = 1'b1; evs = 1'b1; eb = 1'b1; ef = 1'b0;
        if (Reset2) begin
          ea = exp_addr[i];
          if (p >= 0) begin
            h = hpos(p);
            v = vpos(i, p);
            ehs = !(h >= HSS && h < HSE);
            evs = !(v >= VSS[i] && v < VSE[i]);
            eb  = !(h < HV && v < VV[i]);
            if (win_p(i, p)) er = mem[addr_p(i, p)];
            else if (!eb)    er = 3'd4;
            ef  = (e % 2 == 0) && (h == 0) && (v == 0);
          end
        end
        chk($sformatf("i%0d e%0d addr", i, e), addr_o[i], ea);
        chk($sformatf("i%0d e%0d rgb", i, e), rgb_o[i], er);
        chk($sformatf("i%0d e%0d hs", i, e), hs_o[i], ehs);
        chk($sformatf("i%0d e%0d vs", i, e), vs_o[i], evs);
        chk($sformatf("i%0d e%0d blank", i, e), blank_o[i], eb);
        chk($sformatf("i%0d e%0d fs", i, e), fs_o[i], ef);
        if (i == 1 && Reset2 && kt >= 0) begin
          h = hpos(kt);
          v = vpos(1, kt);
          if (h == 192 && v == 1) chk("addr_origin", addr_o[1], 16'h0000);
          if (h == 200 && v == 2) chk("addr_0108", addr_o[1], 16'h0108);
          if (h == 447 && v == 1) chk("addr_00FF", addr_o[1], 16'h00FF);
          if (p >= 0) begin
            h = hpos(p);
            v = vpos(1, p);
            if (h == 197 && v == 1) chk("rgb_197", rgb_o[1], 5);
            if (h == 191 && v == 1) begin
              chk("rgb_191", rgb_o[1], 4);
              chk("blank_191", blank_o[1], 0);
            end
            if (h == 700 && v == 1) begin
              chk("rgb_700", rgb_o[1], 0);
              chk("blank_700", blank_o[1], 1);
            end
          end
        end
      end
    end
  end

  task automatic chk_reset_vals(input string tag);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("%s i%0d addr", tag, i), addr_o[i], 16'h0);
      chk($sformatf("%s i%0d rgb", tag, i), rgb_o[i], 0);
      chk($sformatf("%s i%0d hs", tag, i), hs_o[i], 1);
      chk($sformatf("%s i%0d vs", tag, i), vs_o[i], 1);
      chk($sformatf("%s i%0d blank", tag, i), blank_o[i], 1);
      chk($sformatf("%s i%0d fs", tag, i), fs_o[i], 0);
    end
  endtask

  // Drop Reset2 between edges, confirm outputs clear before the next edge
  task automatic do_reset(input int hold);
    @(posedge Clock);
    #5 Reset2 = 1'b0;
    #1 chk_reset_vals("async_rst");
    repeat (hold) @(posedge Clock);
    #5 Reset2 = 1'b1;
  endtask

  task automatic full_seq();
    int t0, t1, t2, n;
    wait_level(0, 0, 1'b0, 4000, "hs_first");
    chk("hs_first_edge", e, 1316);
    t0 = cyc;
    wait_level(0, 0, 1'b1, 400, "hs_rise");
    t1 = cyc;
    chk("hs_low_width", t1 - t0, 192);
    wait_level(0, 0, 1'b0, 2000, "hs_second");
    t2 = cyc;
    chk("hs_period", t2 - t0, 1600);
    n = 0;
    repeat (1600) begin
      @(negedge Clock);
      if (blank_o[0]) n++;
    end
    chk("blank_per_line", n, 320);
    chk("hs_line3_low", hs_o[0], 0);
  endtask

  task automatic small_seq();
    int tf, tv;
    wait_level(1, 2, 1'b1, 12000, "fs_first");
    chk("fs_blank_first", blank_o[1], 0);
    tf = cyc;
    wait_level(1, 2, 1'b0, 4, "fs_fall");
    wait_level(1, 2, 1'b1, 12000, "fs_second");
    chk("fs_period", cyc - tf, 11200);
    chk("fs_blank_second", blank_o[1], 0);
    wait_level(1, 1, 1'b0, 12000, "vs_fall");
    tv = cyc;
    wait_level(1, 1, 1'b1, 2000, "vs_rise");
    chk("vs_low_width", cyc - tv, 1600);
  endtask

  initial begin
    int n;
    for (int a = 0; a < 65536; a++)
      mem[a] = ((a >> 8) == 0) ? 3'(a & 7) : 3'($urandom_range(0, 7));

    Reset2 = 1'b0;
    repeat (5) @(posedge Clock);
    @(negedge Clock);
    chk_reset_vals("reset");
    @(posedge Clock);
    #5 Reset2 = 1'b1;

    fork
      full_seq();
      small_seq();
    join

    n = 0;
    @(negedge Clock);
    while (e % 1600 != 600 && n < 4000) begin
      @(negedge Clock);
      n++;
    end
    do_reset(3);
    wait_level(0, 0, 1'b0, 2000, "hs_after_rst");
    chk("hs_after_midline_rst", e, 1316);

    for (int r = 0; r < 3; r++) begin
      repeat ($urandom_range(1, 3000)) @(posedge Clock);
      do_reset($urandom_range(1, 4));
      wait_level(0, 0, 1'b0, 2000, "hs_after_rand_rst");
      chk($sformatf("hs_after_rand_rst%0d", r), e, 1316);
    end

    repeat (200) @(posedge Clock);
    @(negedge Clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
